// File: rtl/uart_wb_arbiter.sv
// Two-requester round-robin arbiter in front of a single UART Wishbone-style slave.
// Adds a grant timeout that signals an error, and a drain phase that completes the 4-phase handshake.
//
// state | meaning
// IDLE  | no grant; arbitrate pending strobes
// GNT0  | requester 0 owns the slave
// GNT1  | requester 1 owns the slave
// ERR   | slave never acked; error to granted requester until its strobe drops
// DRAIN | strobe released; wait for slave ack to fall before re-arbitrating
module uart_wb_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] m0_addr,
   input  logic [7:0] m0_data_in,
   output logic [7:0] m0_data_out,
   input  logic       m0_we,
   input  logic       m0_stb,
   output logic       m0_ack,
   output logic       m0_err,
   input  logic [1:0] m1_addr,
   input  logic [7:0] m1_data_in,
   output logic [7:0] m1_data_out,
   input  logic       m1_we,
   input  logic       m1_stb,
   output logic       m1_ack,
   output logic       m1_err,
   output logic [1:0] s_addr,
   output logic [7:0] s_data_in,
   output logic       s_we,
   output logic       s_stb,
   input  logic [7:0] s_data_out,
   input  logic       s_ack
);

   typedef enum logic [2:0] {IDLE, GNT0, GNT1, ERR, DRAIN} state_t;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   state_t     state;
   logic       last_grant;
   logic [7:0] to_cnt;
   logic       ack_seen;
   logic       cur_stb;
   logic [7:0] to_cnt_inc;

   // last_grant doubles as the index of the current owner once a grant is taken
   assign cur_stb    = last_grant ? m1_stb : m0_stb;
   assign to_cnt_inc = to_cnt + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         to_cnt     <= 8'd0;
         ack_seen   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               to_cnt   <= 8'd0;
               ack_seen <= 1'b0;
               if (m0_stb && m1_stb) begin
                  state      <= last_grant ? GNT0 : GNT1;
                  last_grant <= ~last_grant;
               end else if (m0_stb) begin
                  state      <= GNT0;
                  last_grant <= 1'b0;
               end else if (m1_stb) begin
                  state      <= GNT1;
                  last_grant <= 1'b1;
               end
            end
            GNT0, GNT1: begin
               // strobe drop ends the grant whether or not an ack arrived (abort case)
               if (!cur_stb) begin
                  state <= DRAIN;
               end else if (s_ack) begin
                  ack_seen <= 1'b1;
               end else if (!ack_seen) begin
                  if (to_cnt_inc >= TO_LIMIT) state <= ERR;
                  to_cnt <= (to_cnt >= TO_LIMIT) ? TO_LIMIT : to_cnt_inc;
               end
            end
            ERR: begin
               if (!cur_stb) state <= DRAIN;
            end
            DRAIN: begin
               if (!s_ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      s_addr      = 2'd0;
      s_data_in   = 8'd0;
      s_we        = 1'b0;
      s_stb       = 1'b0;
      m0_ack      = 1'b0;
      m1_ack      = 1'b0;
      m0_err      = 1'b0;
      m1_err      = 1'b0;
      m0_data_out = 8'd0;
      m1_data_out = 8'd0;
      if (!reset) begin
         case (state)
            GNT0: begin
               s_addr      = m0_addr;
               s_data_in   = m0_data_in;
               s_we        = m0_we;
               s_stb       = m0_stb;
               m0_ack      = s_ack;
               m0_data_out = s_data_out;
            end
            GNT1: begin
               s_addr      = m1_addr;
               s_data_in   = m1_data_in;
               s_we        = m1_we;
               s_stb       = m1_stb;
               m1_ack      = s_ack;
               m1_data_out = s_data_out;
            end
            ERR: begin
               if (last_grant) m1_err = 1'b1;
               else            m0_err = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
